vga_fb_write_arbiter: RTL

//  Owns write port A of the VGA frame buffer.

---
 rtl/vga_fb_write_arbiter_if.sv | 25 ++
 rtl/vga_fb_write_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_write_arbiter_if.sv
// rtl/vga_fb_write_arbiter_if.sv - bus, pixel-port and frame-buffer port A signal bundle
interface vga_fb_write_arbiter_if;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_data;
  logic        bus_we;
  logic        pix_req;
  logic [14:0] pix_addr;
  logic        pix_data;
  logic        pix_ack;
  logic [14:0] fb_addr;
  logic        fb_data;
  logic        fb_we;
  logic        busy;
  logic        irq;

  modport master (
    output bus_addr, bus_data, bus_we, pix_req, pix_addr, pix_data,
    input  pix_ack, fb_addr, fb_data, fb_we, busy, irq
  );

  modport slave (
    input  bus_addr, bus_data, bus_we, pix_req, pix_addr, pix_data,
    output pix_ack, fb_addr, fb_data, fb_we, busy, irq
  );
endinterface

// File: rtl/vga_fb_write_arbiter.sv
// rtl/vga_fb_write_arbiter.sv - frame buffer port A arbiter: pixel writes over a rectangle-fill engine
// Optional latched fill-complete interrupt enabled by defining VGA_FILL_IRQ_EN.
module vga_fb_write_arbiter #(
  parameter logic [7:0] FillBaseAddr = 8'hB4,
  parameter int         X_MAX        = 159,
  parameter int         Y_MAX        = 119
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  vga_fb_write_arbiter_if.slave  io_fbw
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] X_LIM = X_MAX[7:0];
  localparam logic [6:0] Y_LIM = Y_MAX[6:0];

  logic [1:0]  r_state;
  logic [7:0]  r_x0;
  logic [6:0]  r_y0;
  logic [7:0]  r_x1;
  logic [6:0]  r_y1;
  logic [7:0]  r_cx;
  logic [6:0]  r_cy;
  logic [7:0]  r_bx0;
  logic [7:0]  r_bx1;
  logic [6:0]  r_by1;
  logic        r_fill_val;
  logic        r_setup;
  logic [14:0] r_fb_addr;
  logic        r_fb_data;
  logic        r_fb_we;
  logic        r_pix_ack;

  logic        w_cmd_wr;
  logic        w_start;
  logic        w_abort;
  logic [7:0]  w_cx0;
  logic [7:0]  w_cx1;
  logic [6:0]  w_cy0;
  logic [6:0]  w_cy1;
  logic        w_degen;
  logic        w_pix_grant;
  logic        w_fill_go;
  logic        w_last_x;
  logic        w_last;

  function automatic logic [7:0] clamp_x(input logic [7:0] v);
    return (v > X_LIM) ? X_LIM : v;
  endfunction

  function automatic logic [6:0] clamp_y(input logic [6:0] v);
    return (v > Y_LIM) ? Y_LIM : v;
  endfunction

  assign w_cmd_wr = io_fbw.bus_we && (io_fbw.bus_addr == FillBaseAddr + 8'd4);
  assign w_abort  = w_cmd_wr && io_fbw.bus_data[2];
  assign w_start  = w_cmd_wr && io_fbw.bus_data[0] && !io_fbw.bus_data[2];

  assign w_cx0   = clamp_x(r_x0);
  assign w_cx1   = clamp_x(r_x1);
  assign w_cy0   = clamp_y(r_y0);
  assign w_cy1   = clamp_y(r_y1);
  assign w_degen = (w_cx1 < w_cx0) || (w_cy1 < w_cy0);

  // The pixel port may not be granted in its own ACK cycle, leaving every other slot to the fill.
  assign w_pix_grant = io_fbw.pix_req && !r_pix_ack;
  assign w_fill_go   = (r_state == ST_FILL) && !r_setup && !w_pix_grant && !w_abort;
  assign w_last_x    = (r_cx == r_bx1);
  assign w_last      = w_last_x && (r_cy == r_by1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x0 <= 8'd0;
      r_y0 <= 7'd0;
      r_x1 <= 8'd0;
      r_y1 <= 7'd0;
    end else if (io_fbw.bus_we) begin
      if (io_fbw.bus_addr == FillBaseAddr)         r_x0 <= io_fbw.bus_data;
      if (io_fbw.bus_addr == FillBaseAddr + 8'd1)  r_y0 <= io_fbw.bus_data[6:0];
      if (io_fbw.bus_addr == FillBaseAddr + 8'd2)  r_x1 <= io_fbw.bus_data;
      if (io_fbw.bus_addr == FillBaseAddr + 8'd3)  r_y1 <= io_fbw.bus_data[6:0];
    end
  end

  // The first FILL cycle is a setup slot: cursor and bounds settle before the first write is issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cx       <= 8'd0;
      r_cy       <= 7'd0;
      r_bx0      <= 8'd0;
      r_bx1      <= 8'd0;
      r_by1      <= 7'd0;
      r_fill_val <= 1'b0;
      r_setup    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cx       <= w_cx0;
            r_cy       <= w_cy0;
            r_bx0      <= w_cx0;
            r_bx1      <= w_cx1;
            r_by1      <= w_cy1;
            r_fill_val <= io_fbw.bus_data[1];
            r_setup    <= 1'b1;
            r_state    <= w_degen ? ST_DONE : ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_setup <= 1'b0;
          end else if (r_setup) begin
            r_setup <= 1'b0;
          end else if (w_fill_go) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else if (w_last_x) begin
              r_cx <= r_bx0;
              r_cy <= r_cy + 7'd1;
            end else begin
              r_cx <= r_cx + 8'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_setup <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fb_addr <= 15'd0;
      r_fb_data <= 1'b0;
      r_fb_we   <= 1'b0;
      r_pix_ack <= 1'b0;
    end else if (w_pix_grant) begin
      r_fb_addr <= io_fbw.pix_addr;
      r_fb_data <= io_fbw.pix_data;
      r_fb_we   <= 1'b1;
      r_pix_ack <= 1'b1;
    end else if (w_fill_go) begin
      r_fb_addr <= {r_cy, r_cx};
      r_fb_data <= r_fill_val;
      r_fb_we   <= 1'b1;
      r_pix_ack <= 1'b0;
    end else begin
      r_fb_we   <= 1'b0;
      r_pix_ack <= 1'b0;
    end
  end

  assign io_fbw.fb_addr = r_fb_addr;
  assign io_fbw.fb_data = r_fb_data;
  assign io_fbw.fb_we   = r_fb_we;
  assign io_fbw.pix_ack = r_pix_ack;
  assign io_fbw.busy    = (r_state != ST_IDLE);

`ifdef VGA_FILL_IRQ_EN
  logic r_irq;
  logic w_irq_clr;

  assign w_irq_clr = w_cmd_wr && io_fbw.bus_data[7];

  // Set takes priority over a same-cycle clear so a completion is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_irq <= 1'b1;
    end else if (w_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign io_fbw.irq = r_irq;
`else
  assign io_fbw.irq = 1'b0;
`endif

endmodule
